// File: rtl/anubis_pkg.sv
// Shared types and constants for the Anubis round-constant sequencer.
// Holds the AES S-box, the round-count helper and the sequencer states.
package anubis_pkg;

  localparam int RC_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int anubis_rounds(input int n);
    return 8 + n;
  endfunction

endpackage

// File: rtl/rc_word_lut.sv
// Combinational round-constant lookup: round r in, 128-bit constant out.
// Top word is S[4(r-1)+0..3], the low 96 bits are zero.
module rc_word_lut
  import anubis_pkg::*;
(
  input  logic [4:0]      round,
  output logic [RC_W-1:0] word
);

  logic [7:0] base;

  // 4*(r-1) in 8 bits; largest legal index is 71
  assign base = {1'b0, round - 5'd1, 2'b00};

  assign word = {
    SBOX[base],
    SBOX[base + 8'd1],
    SBOX[base + 8'd2],
    SBOX[base + 8'd3],
    96'd0
  };

endmodule

// File: rtl/anubis_rc_sequencer.sv
// Anubis round-constant sequencer with valid/ready output handshake.
// Define RC_REVERSE_EN to enable reverse (decryption) round order via dir.
module anubis_rc_sequencer
  import anubis_pkg::*;
#(
  parameter int N_KEY_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dir,
  output logic [RC_W-1:0] rc_data,
  output logic [4:0]      rc_round,
  output logic            rc_last,
  output logic            rc_valid,
  input  logic            rc_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0] R =
    5'(anubis_rounds(N_KEY_WORDS));

  state_e          state, state_n;
  logic [4:0]      cnt, cnt_n;
  logic [4:0]      cnt_load, cnt_step;
  logic            last_n;
  logic            ld;
  logic [RC_W-1:0] lut_word;

  rc_word_lut u_lut (
    .round (cnt),
    .word  (lut_word)
  );

`ifdef RC_REVERSE_EN
  logic dir_q, dir_n;

  assign cnt_load = dir ? R : 5'd1;
  assign cnt_step = dir_q ? cnt - 5'd1
                          : cnt + 5'd1;
  assign last_n   = dir_q ? (cnt == 5'd1)
                          : (cnt == R);

  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_n;
  end

  always_comb begin
    dir_n = dir_q;
    if (state == IDLE && start) dir_n = dir;
  end
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign cnt_load   = 5'd1;
  assign cnt_step   = cnt + 5'd1;
  assign last_n     = (cnt == R);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          cnt_n   = cnt_load;
        end
      end
      FETCH: begin
        ld      = 1'b1;
        state_n = PRESENT;
      end
      PRESENT: begin
        if (rc_ready) begin
          if (rc_last) begin
            state_n = DONE;
          end else begin
            state_n = FETCH;
            cnt_n   = cnt_step;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      rc_data  <= '0;
      rc_round <= 5'd0;
      rc_last  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ld) begin
        rc_data  <= lut_word;
        rc_round <= cnt;
        rc_last  <= last_n;
      end
    end
  end

  // Flags decode straight from the state register
  assign rc_valid = (state == PRESENT);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_anubis_rc_sequencer.sv
// Self-checking bench for anubis_rc_sequencer (N=4 and N=10 instances).
// Scoreboard queues feed expected constants; a table checks key rounds.
module tb_anubis_rc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s4, d4, rdy4;
  logic [127:0] dat4;
  logic [4:0] rnd4;
  logic lst4, v4, bsy4, dn4;
  logic s10, d10, rdy10;
  logic [127:0] dat10;
  logic [4:0] rnd10;
  logic lst10, v10, bsy10, dn10;

  anubis_rc_sequencer #(.N_KEY_WORDS(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .dir(d4),
    .rc_data(dat4), .rc_round(rnd4), .rc_last(lst4),
    .rc_valid(v4), .rc_ready(rdy4),
    .busy(bsy4), .done(dn4)
  );

  anubis_rc_sequencer #(.N_KEY_WORDS(10)) u10 (
    .clk(clk), .rst(rst), .start(s10), .dir(d10),
    .rc_data(dat10), .rc_round(rnd10), .rc_last(lst10),
    .rc_valid(v10), .rc_ready(rdy10),
    .busy(bsy10), .done(dn10)
  );

`ifdef RC_REVERSE_EN
  localparam bit REV_OK = 1'b1;
`else
  localparam bit REV_OK = 1'b0;
`endif

  localparam logic [0:79][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84
  };

  typedef struct {
    logic [4:0]   rnd;
    logic [127:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    bit          sel;
    int          rnd;
    logic [31:0] hi;
    bit          last;
  } vec_t;

  int npass = 0;
  int ntot  = 0;
  int hs4   = 0;
  int hs10  = 0;
  exp_t q4[$];
  exp_t q10[$];
  logic [127:0] cap4 [32];
  logic         cl4  [32];
  logic [127:0] cap10 [32];
  logic         cl10  [32];

  function automatic logic [127:0] expw(input int r);
    int b;
    b = 4 * (r - 1);
    return {SB[b], SB[b+1], SB[b+2], SB[b+3], 96'd0};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push(input bit sel, input bit rev);
    int nr;
    nr = sel ? 18 : 12;
    for (int i = 1; i <= nr; i++) begin
      int r;
      exp_t e;
      r = rev ? nr + 1 - i : i;
      e.rnd  = 5'(r);
      e.data = expw(r);
      e.last = rev ? (r == 1) : (r == nr);
      if (sel) q10.push_back(e);
      else     q4.push_back(e);
    end
  endtask

  task automatic go(input bit sel, input bit d);
    if (sel) begin s10 = 1'b1; d10 = d; end
    else     begin s4 = 1'b1;  d4 = d;  end
    push(sel, d & REV_OK);
    @(posedge clk); #1;
    s4 = 1'b0; d4 = 1'b0; s10 = 1'b0; d10 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int n);
    n = 1;
    while (!(sel ? dn10 : dn4) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(sel ? dn10 : dn4))
      chk("done_timeout", {127'd0, sel ? dn10 : dn4}, 1);
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && v4 && rdy4) begin
      hs4++;
      cap4[rnd4] = dat4;
      cl4[rnd4]  = lst4;
      if (q4.size() == 0) begin
        chk("sb4_unexpected_round", {123'd0, rnd4}, 0);
      end else begin
        e = q4.pop_front();
        chk("sb4_data", dat4, e.data);
        chk("sb4_round", {123'd0, rnd4}, {123'd0, e.rnd});
        chk("sb4_last", {127'd0, lst4}, {127'd0, e.last});
      end
    end
  end

  always @(negedge clk) begin : mon10
    exp_t e;
    if (!rst && v10 && rdy10) begin
      hs10++;
      cap10[rnd10] = dat10;
      cl10[rnd10]  = lst10;
      if (q10.size() == 0) begin
        chk("sb10_unexpected_round", {123'd0, rnd10}, 0);
      end else begin
        e = q10.pop_front();
        chk("sb10_data", dat10, e.data);
        chk("sb10_round", {123'd0, rnd10}, {123'd0, e.rnd});
        chk("sb10_last", {127'd0, lst10}, {127'd0, e.last});
      end
    end
  end

  initial begin
    vec_t tbl [7];
    int n, k, base, dcnt;

    tbl[0] = '{0, 1,  32'h637c777b, 0};
    tbl[1] = '{0, 2,  32'hf26b6fc5, 0};
    tbl[2] = '{0, 3,  32'h3001672b, 0};
    tbl[3] = '{0, 12, 32'h71d83115, 1};
    tbl[4] = '{1, 1,  32'h637c777b, 0};
    tbl[5] = '{1, 17, 32'h09832c1a, 0};
    tbl[6] = '{1, 18, 32'h1b6e5aa0, 1};

    rst = 1'b1;
    s4 = 0; d4 = 0; rdy4 = 1;
    s10 = 0; d10 = 0; rdy10 = 1;
    repeat (2) @(posedge clk);
    #1 s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    chk("rst_data", dat4, 0);
    chk("rst_round", {123'd0, rnd4}, 0);
    chk("rst_last", {127'd0, lst4}, 0);
    chk("rst_valid", {127'd0, v4}, 0);
    chk("rst_busy_start_ignored", {127'd0, bsy4}, 0);
    chk("rst_done", {127'd0, dn4}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // forward run, ready tied high, cycle-accurate timing
    go(0, 0);
    chk("fwd_fetch_busy", {127'd0, bsy4}, 1);
    chk("fwd_fetch_novalid", {127'd0, v4}, 0);
    @(posedge clk); #1;
    chk("fwd_t2_valid", {127'd0, v4}, 1);
    n = 2;
    while (!dn4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fwd_done_cycle", n, 25);
    chk("fwd_done_busy", {127'd0, bsy4}, 1);
    @(posedge clk); #1;
    chk("fwd_idle_busy", {127'd0, bsy4}, 0);
    chk("fwd_idle_done", {127'd0, dn4}, 0);
    chk("fwd_q_empty", q4.size(), 0);

    // reverse request (honoured only with RC_REVERSE_EN)
    go(0, 1);
    wait_done(0, n);
    chk("rev_done_cycle", n, 25);
    @(posedge clk); #1;
    chk("rev_q_empty", q4.size(), 0);

    // backpressure on round 3
    go(0, 0);
    k = 0;
    while (!(v4 && rnd4 == 5'd3) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    rdy4 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", {127'd0, v4}, 1);
      chk("bp_data", dat4, {32'h3001672b, 96'd0});
      chk("bp_round", {123'd0, rnd4}, 3);
    end
    rdy4 = 1'b1;
    wait_done(0, n);
    @(posedge clk); #1;
    chk("bp_q_empty", q4.size(), 0);

    // start pulsed during FETCH of round 2
    base = hs4;
    go(0, 0);
    k = 0;
    while (!(v4 && rnd4 == 5'd1) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("busy_start_in_fetch", {127'd0, v4}, 0);
    s4 = 1'b1; d4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0; d4 = 1'b0;
    chk("busy_start_round2", {123'd0, rnd4}, 2);
    wait_done(0, n);
    @(posedge clk); #1;
    chk("busy_start_count", hs4 - base, 12);

    // reset during round 5
    go(0, 0);
    k = 0;
    while (!(v4 && rnd4 == 5'd5) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_data", dat4, 0);
    chk("mid_rst_round", {123'd0, rnd4}, 0);
    chk("mid_rst_last", {127'd0, lst4}, 0);
    chk("mid_rst_valid", {127'd0, v4}, 0);
    chk("mid_rst_busy", {127'd0, bsy4}, 0);
    q4.delete();
    rst = 1'b0;
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dn4) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    go(0, 0);
    wait_done(0, n);
    @(posedge clk); #1;
    chk("restart_q_empty", q4.size(), 0);

    // N=10 forward run
    go(1, 0);
    wait_done(1, n);
    chk("n10_done_cycle", n, 37);
    @(posedge clk); #1;
    chk("n10_q_empty", q10.size(), 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sel) begin
        chk($sformatf("tbl10_r%0d_data", tbl[i].rnd),
            cap10[tbl[i].rnd], {tbl[i].hi, 96'd0});
        chk($sformatf("tbl10_r%0d_last", tbl[i].rnd),
            {127'd0, cl10[tbl[i].rnd]}, {127'd0, tbl[i].last});
      end else begin
        chk($sformatf("tbl4_r%0d_data", tbl[i].rnd),
            cap4[tbl[i].rnd], {tbl[i].hi, 96'd0});
        chk($sformatf("tbl4_r%0d_last", tbl[i].rnd),
            {127'd0, cl4[tbl[i].rnd]}, {127'd0, tbl[i].last});
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
